// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the flappy game-flow sequencer.
// State encoding and BCD digit width used by the sequencer and score counter.
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    PHYS       = 3'd2,
    SCROLL     = 3'd3,
    CHECK      = 3'd4,
    LOSE       = 3'd5
  } state_t;

  localparam int BCD_W = 4;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter that saturates at 99.
// Synchronous clear and increment; asynchronous active-high reset.
module bcd_score_counter
  import game_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] score_bcd
);

  logic [BCD_W-1:0] ones_q, ones_d;
  logic [BCD_W-1:0] tens_q, tens_d;

  function automatic logic [2*BCD_W-1:0] bcd_sat_inc(input logic [2*BCD_W-1:0] v);
    logic [BCD_W-1:0] t;
    logic [BCD_W-1:0] o;
    t = v[2*BCD_W-1:BCD_W];
    o = v[BCD_W-1:0];
    if (t == BCD_W'(9) && o == BCD_W'(9)) begin
      return v;
    end else if (o == BCD_W'(9)) begin
      return {t + BCD_W'(1), BCD_W'(0)};
    end else begin
      return {t, o + BCD_W'(1)};
    end
  endfunction

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = '0;
      tens_d = '0;
    end else if (inc) begin
      {tens_d, ones_d} = bcd_sat_inc({tens_q, ones_q});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign score_bcd = {tens_q, ones_q};

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: divides frame ticks into steps of physics, scroll and
// collision check, tracks Initial/Run/Lose state, flap requests and the score.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int FRAME_DIV     = 2,
  parameter int CHECK_TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ack,
  input  logic       frame_tick,
  input  logic       flap_pulse,
  input  logic       phys_done,
  input  logic       check_done,
  input  logic       collide,
  input  logic       pipe_passed,
  output logic       phys_en,
  output logic       flap_req,
  output logic       scroll_en,
  output logic       check_req,
  output logic       q_initial,
  output logic       q_run,
  output logic       q_lose,
  output logic [7:0] score_bcd,
  output logic       overrun,
  output logic       fault
);

  localparam logic [3:0] FDIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [7:0] TMO_LAST  = 8'(CHECK_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       pend_q, pend_d;
  logic       phys_en_q, phys_en_d;
  logic       flap_req_q, flap_req_d;
  logic       scroll_en_q, scroll_en_d;
  logic       check_req_q, check_req_d;
  logic       overrun_q, overrun_d;
  logic       fault_q, fault_d;
  logic       q_initial_q, q_initial_d;
  logic       q_run_q, q_run_d;
  logic       q_lose_q, q_lose_d;
  logic       score_clr, score_inc;
  logic       in_run, in_step;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    pend_d      = pend_q;
    phys_en_d   = 1'b0;
    flap_req_d  = 1'b0;
    scroll_en_d = 1'b0;
    check_req_d = check_req_q;
    fault_d     = fault_q;
    score_clr   = 1'b0;
    score_inc   = 1'b0;

    in_step   = (state_q == PHYS) || (state_q == SCROLL) || (state_q == CHECK);
    in_run    = in_step || (state_q == WAIT_FRAME);
    overrun_d = frame_tick && in_step;

    if (in_run && flap_pulse) begin
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          score_clr   = 1'b1;
          fault_d     = 1'b0;
          frame_cnt_d = '0;
          pend_d      = 1'b0;
          state_d     = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_tick) begin
          if (frame_cnt_q == FDIV_LAST) begin
            frame_cnt_d = '0;
            phys_en_d   = 1'b1;
            flap_req_d  = pend_q | flap_pulse;
            pend_d      = 1'b0;
            state_d     = PHYS;
          end else begin
            frame_cnt_d = frame_cnt_q + 4'd1;
          end
        end
      end
      PHYS: begin
        if (phys_done) begin
          scroll_en_d = 1'b1;
          state_d     = SCROLL;
        end
      end
      SCROLL: begin
        check_req_d = 1'b1;
        tmo_cnt_d   = '0;
        state_d     = CHECK;
      end
      CHECK: begin
        if (check_done) begin
          check_req_d = 1'b0;
          if (collide) begin
            state_d = LOSE;
          end else begin
            score_inc = pipe_passed;
            state_d   = WAIT_FRAME;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          check_req_d = 1'b0;
          fault_d     = 1'b1;
          state_d     = LOSE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      LOSE: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        check_req_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    q_initial_d = (state_d == IDLE);
    q_lose_d    = (state_d == LOSE);
    q_run_d     = !q_initial_d && !q_lose_d;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      pend_q      <= 1'b0;
      phys_en_q   <= 1'b0;
      flap_req_q  <= 1'b0;
      scroll_en_q <= 1'b0;
      check_req_q <= 1'b0;
      overrun_q   <= 1'b0;
      fault_q     <= 1'b0;
      q_initial_q <= 1'b1;
      q_run_q     <= 1'b0;
      q_lose_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      pend_q      <= pend_d;
      phys_en_q   <= phys_en_d;
      flap_req_q  <= flap_req_d;
      scroll_en_q <= scroll_en_d;
      check_req_q <= check_req_d;
      overrun_q   <= overrun_d;
      fault_q     <= fault_d;
      q_initial_q <= q_initial_d;
      q_run_q     <= q_run_d;
      q_lose_q    <= q_lose_d;
    end
  end

  bcd_score_counter u_score (
    .clk       (Clk),
    .rst       (reset),
    .clr       (score_clr),
    .inc       (score_inc),
    .score_bcd (score_bcd)
  );

  assign phys_en   = phys_en_q;
  assign flap_req  = flap_req_q;
  assign scroll_en = scroll_en_q;
  assign check_req = check_req_q;
  assign overrun   = overrun_q;
  assign fault     = fault_q;
  assign q_initial = q_initial_q;
  assign q_run     = q_run_q;
  assign q_lose    = q_lose_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer (FRAME_DIV=2, CHECK_TIMEOUT=15).
module tb_game_sequencer;

  logic       Clk;
  logic       reset;
  logic       start, ack, frame_tick, flap_pulse;
  logic       phys_done, check_done, collide, pipe_passed;
  logic       phys_en, flap_req, scroll_en, check_req;
  logic       q_initial, q_run, q_lose, overrun, fault;
  logic [7:0] score_bcd;

  int vectors    = 0;
  int miscompares = 0;
  int phys_cnt   = 0;

  game_sequencer #(.FRAME_DIV(2), .CHECK_TIMEOUT(15)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .start       (start),
    .ack         (ack),
    .frame_tick  (frame_tick),
    .flap_pulse  (flap_pulse),
    .phys_done   (phys_done),
    .check_done  (check_done),
    .collide     (collide),
    .pipe_passed (pipe_passed),
    .phys_en     (phys_en),
    .flap_req    (flap_req),
    .scroll_en   (scroll_en),
    .check_req   (check_req),
    .q_initial   (q_initial),
    .q_run       (q_run),
    .q_lose      (q_lose),
    .score_bcd   (score_bcd),
    .overrun     (overrun),
    .fault       (fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (phys_en) phys_cnt <= phys_cnt + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  // One full game step; phys_done arrives together with phys_en.
  task automatic run_step(input logic flap_in, input logic flap_exp,
                          input logic col, input logic pass);
    if (flap_in) begin
      flap_pulse = 1'b1;
      cyc();
      flap_pulse = 1'b0;
    end
    tick();
    check("div_hold", {7'd0, phys_en}, 8'd0);
    tick();
    check("phys_en", {7'd0, phys_en}, 8'd1);
    check("flap_req", {7'd0, flap_req}, {7'd0, flap_exp});
    phys_done = 1'b1;
    cyc();
    phys_done = 1'b0;
    check("scroll_en", {7'd0, scroll_en}, 8'd1);
    check("phys_en_drop", {7'd0, phys_en}, 8'd0);
    cyc();
    check("check_req", {7'd0, check_req}, 8'd1);
    check("scroll_drop", {7'd0, scroll_en}, 8'd0);
    check_done  = 1'b1;
    collide     = col;
    pipe_passed = pass;
    cyc();
    check_done  = 1'b0;
    collide     = 1'b0;
    pipe_passed = 1'b0;
    check("check_req_drop", {7'd0, check_req}, 8'd0);
    check("q_lose_after", {7'd0, q_lose}, {7'd0, col});
  endtask

  initial begin
    reset = 1'b1;
    start = 0; ack = 0; frame_tick = 0; flap_pulse = 0;
    phys_done = 0; check_done = 0; collide = 0; pipe_passed = 0;
    cyc();
    cyc();
    check("rst_q_initial", {7'd0, q_initial}, 8'd1);
    check("rst_q_run", {7'd0, q_run}, 8'd0);
    check("rst_q_lose", {7'd0, q_lose}, 8'd0);
    check("rst_score", score_bcd, 8'h00);
    check("rst_strobes", {4'd0, phys_en, scroll_en, check_req, overrun}, 8'd0);
    check("rst_fault", {7'd0, fault}, 8'd0);
    reset = 1'b0;
    cyc();
    check("idle_hold", {7'd0, q_initial}, 8'd1);

    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_run", {7'd0, q_run}, 8'd1);
    check("start_initial", {7'd0, q_initial}, 8'd0);

    run_step(0, 0, 0, 0);
    run_step(0, 0, 0, 0);
    check("phys_pulses", phys_cnt[7:0], 8'd2);
    check("score_00", score_bcd, 8'h00);

    run_step(1, 1, 0, 0);
    run_step(0, 0, 0, 0);

    for (int i = 0; i < 12; i++) run_step(0, 0, 0, 1);
    check("score_12", score_bcd, 8'h12);
    for (int i = 0; i < 87; i++) run_step(0, 0, 0, 1);
    check("score_99", score_bcd, 8'h99);
    run_step(0, 0, 0, 1);
    check("score_sat", score_bcd, 8'h99);

    run_step(0, 0, 1, 1);
    check("lose_99_score", score_bcd, 8'h99);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    check("ack_idle", {7'd0, q_initial}, 8'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_score", score_bcd, 8'h00);

    for (int i = 0; i < 5; i++) run_step(0, 0, 0, 1);
    check("score_05", score_bcd, 8'h05);
    run_step(0, 0, 1, 1);
    check("collide_score", score_bcd, 8'h05);
    check("collide_fault", {7'd0, fault}, 8'd0);

    start = 1'b1;
    cyc();
    check("lose_ignores_start", {7'd0, q_lose}, 8'd1);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    check("held_start_idle", {7'd0, q_initial}, 8'd1);
    cyc();
    start = 1'b0;
    check("held_start_run", {7'd0, q_run}, 8'd1);
    check("held_start_score", score_bcd, 8'h00);

    tick();
    tick();
    phys_done = 1'b1;
    cyc();
    phys_done = 1'b0;
    cyc();
    check("tmo_entry", {7'd0, check_req}, 8'd1);
    for (int i = 0; i < 14; i++) cyc();
    check("tmo_early", {7'd0, q_lose}, 8'd0);
    check("tmo_req_held", {7'd0, check_req}, 8'd1);
    cyc();
    check("tmo_lose", {7'd0, q_lose}, 8'd1);
    check("tmo_fault", {7'd0, fault}, 8'd1);
    check("tmo_req_drop", {7'd0, check_req}, 8'd0);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    check("fault_hold_idle", {7'd0, fault}, 8'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("fault_clear", {7'd0, fault}, 8'd0);

    tick();
    tick();
    check("ovr_phys", {7'd0, phys_en}, 8'd1);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check("overrun_pulse", {7'd0, overrun}, 8'd1);
    check("phys_wait", {7'd0, scroll_en}, 8'd0);
    cyc();
    check("overrun_drop", {7'd0, overrun}, 8'd0);
    phys_done = 1'b1;
    cyc();
    phys_done = 1'b0;
    check("ovr_scroll", {7'd0, scroll_en}, 8'd1);
    cyc();
    check_done = 1'b1;
    cyc();
    check_done = 1'b0;
    run_step(0, 0, 0, 0);

    tick();
    tick();
    phys_done = 1'b1;
    cyc();
    phys_done = 1'b0;
    cyc();
    check("pre_rst_check", {7'd0, check_req}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_initial", {7'd0, q_initial}, 8'd1);
    check("async_req", {7'd0, check_req}, 8'd0);
    check("async_run", {7'd0, q_run}, 8'd0);
    #3;
    reset = 1'b0;
    cyc();
    check("post_rst_idle", {7'd0, q_initial}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
